// File: rtl/ldm_host_loader.sv
// Host-side LDM sequencer: streams a preload into the core's local data memory,
// runs the core through its start/complete handshake, then streams a result region back out.
module ldm_host_loader #(
  parameter int DATA_BITS = 64,
  parameter int CNT_BITS  = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 go_in,
  input  logic [DATA_BITS-1:0] load_base_in,
  input  logic [CNT_BITS-1:0]  load_count_in,
  input  logic [DATA_BITS-1:0] rd_base_in,
  input  logic [CNT_BITS-1:0]  rd_count_in,
  input  logic                 s_valid_in,
  input  logic [DATA_BITS-1:0] s_data_in,
  output logic                 s_ready_out,
  output logic                 m_valid_out,
  output logic [DATA_BITS-1:0] m_data_out,
  input  logic                 m_ready_in,
  output logic [DATA_BITS-1:0] LDM_dina_out_64,
  output logic [DATA_BITS-1:0] LDM_addra_out_64,
  output logic [7:0]           LDM_wea_out,
  input  logic [DATA_BITS-1:0] LDM_douta_in_64,
  output logic                 start_out,
  input  logic                 complete_in,
  output logic                 busy_out,
  output logic                 done_out
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_BITS-1:0] load_base, rd_base;
  logic [CNT_BITS-1:0]  load_cnt, rd_cnt;
  logic [CNT_BITS-1:0]  idx, k, ocnt;
  logic [RD_LAT-1:0]    pipe, pipe_nxt;
  logic [1:0]           occ;
  logic                 wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] fifo [2];
  logic [7:0]           wea_q;
  logic [DATA_BITS-1:0] addr_q, dina_q;
  logic                 go_acc, s_hs, push, pop, issue, last_load, last_pop;

  function automatic logic [DATA_BITS-1:0] word_addr(input logic [DATA_BITS-1:0] base,
                                                     input logic [CNT_BITS-1:0]  i);
    return base + ({{(DATA_BITS-CNT_BITS){1'b0}}, i} << 3);
  endfunction

  function automatic int n_inflight(input logic [RD_LAT-1:0] p);
    int n;
    n = 0;
    for (int i = 0; i < RD_LAT; i++) n += int'(p[i]);
    return n;
  endfunction

  assign go_acc      = (state == S_IDLE) && go_in;
  assign s_ready_out = (state == S_LOAD);
  assign s_hs        = s_valid_in && s_ready_out;
  assign push        = pipe[RD_LAT-1];
  assign m_valid_out = (occ != 2'd0);
  assign pop         = m_valid_out && m_ready_in;
  assign last_load   = s_hs && (idx == load_cnt - CNT_BITS'(1));
  assign last_pop    = pop && (ocnt == rd_cnt - CNT_BITS'(1));

  // A word popped this cycle frees its slot at the same edge, so it is credited
  // back; that keeps one read per cycle in flight without ever overfilling the FIFO.
  assign issue = (state == S_DRAIN) && (k < rd_cnt) &&
                 ((int'(occ) + n_inflight(pipe)) < (2 + int'(pop)));

  always_comb begin
    pipe_nxt    = pipe << 1;
    pipe_nxt[0] = issue;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (go_in) state_nxt = (load_count_in != '0) ? S_LOAD : S_RUN;
      S_LOAD:  if (last_load) state_nxt = S_RUN;
      S_RUN:   if (complete_in) state_nxt = (rd_cnt != '0) ? S_DRAIN : S_DONE;
      S_DRAIN: if (last_pop) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign start_out        = (state == S_RUN);
  assign busy_out         = (state != S_IDLE);
  assign done_out         = (state == S_DONE);
  assign LDM_wea_out      = wea_q;
  assign LDM_dina_out_64  = dina_q;
  assign LDM_addra_out_64 = (state == S_DRAIN) ? word_addr(rd_base, k) : addr_q;
  assign m_data_out       = m_valid_out ? fifo[rd_ptr] : '0;

  // Configuration and FIFO storage: data only, qualified by go/push
  always_ff @(posedge CLK) begin
    if (go_acc) begin
      load_base <= load_base_in;
      load_cnt  <= load_count_in;
      rd_base   <= rd_base_in;
      rd_cnt    <= rd_count_in;
    end
    if (push) fifo[wr_ptr] <= LDM_douta_in_64;
  end

  // Sequencer state, counters, LDM write port and FIFO bookkeeping
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      idx    <= '0;
      k      <= '0;
      ocnt   <= '0;
      pipe   <= '0;
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      wea_q  <= 8'h00;
      addr_q <= '0;
      dina_q <= '0;
    end else begin
      state <= state_nxt;
      wea_q <= s_hs ? 8'hFF : 8'h00;
      if (s_hs) begin
        addr_q <= word_addr(load_base, idx);
        dina_q <= s_data_in;
        idx    <= idx + CNT_BITS'(1);
      end
      if (issue) k <= k + CNT_BITS'(1);
      if (pop) ocnt <= ocnt + CNT_BITS'(1);
      if (go_acc) begin
        idx  <= '0;
        k    <= '0;
        ocnt <= '0;
      end
      pipe <= pipe_nxt;
      occ  <= occ + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

endmodule
